// File: rtl/isect_arbiter_pkg.sv
// Shared types and constants for the intersection-unit arbiter.
package isect_arbiter_pkg;

  // Signed Q16.16 fixed-point word
  typedef logic signed [31:0] fip;

  localparam fip FIP_ONE = 32'sh0001_0000;
  localparam fip FIP_MIN = 32'sh8000_0000;
  localparam fip FIP_MAX = 32'sh7fff_ffff;

  // Triangle: 3 vertices x 3 coords; ray: origin + direction, 3 coords each
  localparam int unsigned TRI_BITS = 288;
  localparam int unsigned RAY_BITS = 192;

endpackage

// File: rtl/isect_tag_fifo.sv
// Tag FIFO remembering which requester owns each in-flight intersection.
module isect_tag_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IDW   = 2
) (
  input  logic           i_clk,
  input  logic           i_rstn,
  input  logic           i_push,
  input  logic [IDW-1:0] i_push_id,
  input  logic           i_pop,
  output logic           o_full,
  output logic           o_empty,
  output logic [IDW-1:0] o_head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [IDW-1:0] mem_q [DEPTH];
  logic [AW:0]    wr_q, wr_d;
  logic [AW:0]    rd_q, rd_d;

  // Extra pointer MSB distinguishes full from empty when the indices match
  assign o_empty = (wr_q == rd_q);
  assign o_full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign o_head  = mem_q[rd_q[AW-1:0]];

  // Pointer advance; overflow/underflow requests are dropped
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (i_push && !o_full)  wr_d = wr_q + 1'b1;
    if (i_pop  && !o_empty) rd_d = rd_q + 1'b1;
  end

  // Pointer registers
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset; validity is tracked by the pointers
  always_ff @(posedge i_clk) begin
    if (i_push && !o_full) mem_q[wr_q[AW-1:0]] <= i_push_id;
  end

endmodule

// File: rtl/isect_arbiter.sv
// Round-robin arbiter sharing one in-order pipelined intersection unit among requesters.
module isect_arbiter
  import isect_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IDW   = $clog2(N_REQ)
) (
  input  logic                      i_clk,
  input  logic                      i_rstn,
  input  logic [N_REQ-1:0]          i_req_valid,
  output logic [N_REQ-1:0]          o_req_ready,
  input  logic [N_REQ*TRI_BITS-1:0] i_req_tri,
  input  logic [N_REQ*RAY_BITS-1:0] i_req_ray,
  output logic                      o_isect_en,
  output logic [TRI_BITS-1:0]       o_isect_tri,
  output logic [RAY_BITS-1:0]       o_isect_ray,
  input  logic                      i_isect_valid,
  input  logic [31:0]               i_isect_t,
  input  logic                      i_isect_hit,
  output logic [N_REQ-1:0]          o_rsp_valid,
  output logic [31:0]               o_rsp_t,
  output logic                      o_rsp_hit,
  input  logic                      i_drain,
  output logic                      o_idle,
  output logic                      o_err
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [IDW-1:0]      start_q, start_d;  // next index to search from
  logic [CW-1:0]       count_q, count_d;
  logic                isect_en_q, isect_en_d;
  logic [TRI_BITS-1:0] tri_q, tri_d;
  logic [RAY_BITS-1:0] ray_q, ray_d;
  logic [N_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  fip                  rsp_t_q, rsp_t_d;
  logic                rsp_hit_q, rsp_hit_d;
  logic                idle_q, idle_d;
  logic                err_q, err_d;

  logic                sel_found;
  logic [IDW-1:0]      sel_idx, cand;
  logic                grant_ok, hs, pop;
  logic                fifo_full, fifo_empty;
  logic [IDW-1:0]      fifo_head;

  // Rotating priority search starting at start_q
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = IDW'((32'(start_q) + k) % N_REQ);
      if (!sel_found && i_req_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Gating on i_rstn keeps ready low while reset is held
  assign grant_ok = i_rstn && !i_drain && !fifo_full && (count_q < CW'(DEPTH));
  assign hs       = grant_ok && sel_found;
  assign pop      = i_isect_valid && !fifo_empty;

  // Ready is one-hot on the selected requester, or zero
  always_comb begin
    o_req_ready = '0;
    if (hs) o_req_ready[sel_idx] = 1'b1;
  end

  // Next-state for issue, response and bookkeeping registers
  always_comb begin
    start_d     = start_q;
    if (hs) start_d = (32'(sel_idx) == N_REQ - 1) ? '0 : sel_idx + 1'b1;
    isect_en_d  = hs;
    tri_d       = hs ? i_req_tri[32'(sel_idx)*TRI_BITS +: TRI_BITS] : tri_q;
    ray_d       = hs ? i_req_ray[32'(sel_idx)*RAY_BITS +: RAY_BITS] : ray_q;
    count_d     = count_q + CW'(hs) - CW'(pop);
    rsp_valid_d = '0;
    if (pop) rsp_valid_d[fifo_head] = 1'b1;
    rsp_t_d     = pop ? fip'(i_isect_t) : rsp_t_q;
    rsp_hit_d   = pop ? i_isect_hit : rsp_hit_q;
    err_d       = err_q || (i_isect_valid && fifo_empty);
    idle_d      = (count_d == '0) && !isect_en_d && (rsp_valid_d == '0);
  end

  // State registers
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      start_q     <= '0;
      count_q     <= '0;
      isect_en_q  <= 1'b0;
      tri_q       <= '0;
      ray_q       <= '0;
      rsp_valid_q <= '0;
      rsp_t_q     <= '0;
      rsp_hit_q   <= 1'b0;
      idle_q      <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      start_q     <= start_d;
      count_q     <= count_d;
      isect_en_q  <= isect_en_d;
      tri_q       <= tri_d;
      ray_q       <= ray_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_t_q     <= rsp_t_d;
      rsp_hit_q   <= rsp_hit_d;
      idle_q      <= idle_d;
      err_q       <= err_d;
    end
  end

  isect_tag_fifo #(
    .DEPTH (DEPTH),
    .IDW   (IDW)
  ) u_tag_fifo (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .i_push    (hs),
    .i_push_id (sel_idx),
    .i_pop     (pop),
    .o_full    (fifo_full),
    .o_empty   (fifo_empty),
    .o_head    (fifo_head)
  );

  assign o_isect_en  = isect_en_q;
  assign o_isect_tri = tri_q;
  assign o_isect_ray = ray_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_t     = rsp_t_q;
  assign o_rsp_hit   = rsp_hit_q;
  assign o_idle      = idle_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_isect_arbiter.sv
// Directed + random bench for isect_arbiter against a queue-based reference model.
module tb_isect_arbiter;

  localparam int N = 4;
  localparam int D = 4;

  logic             i_clk = 1'b0;
  logic             i_rstn;
  logic [N-1:0]     i_req_valid;
  logic [N-1:0]     o_req_ready;
  logic [N*288-1:0] i_req_tri;
  logic [N*192-1:0] i_req_ray;
  logic             o_isect_en;
  logic [287:0]     o_isect_tri;
  logic [191:0]     o_isect_ray;
  logic             i_isect_valid;
  logic [31:0]      i_isect_t;
  logic             i_isect_hit;
  logic [N-1:0]     o_rsp_valid;
  logic [31:0]      o_rsp_t;
  logic             o_rsp_hit;
  logic             i_drain;
  logic             o_idle;
  logic             o_err;

  isect_arbiter #(
    .N_REQ (N),
    .DEPTH (D)
  ) dut (
    .i_clk         (i_clk),
    .i_rstn        (i_rstn),
    .i_req_valid   (i_req_valid),
    .o_req_ready   (o_req_ready),
    .i_req_tri     (i_req_tri),
    .i_req_ray     (i_req_ray),
    .o_isect_en    (o_isect_en),
    .o_isect_tri   (o_isect_tri),
    .o_isect_ray   (o_isect_ray),
    .i_isect_valid (i_isect_valid),
    .i_isect_t     (i_isect_t),
    .i_isect_hit   (i_isect_hit),
    .o_rsp_valid   (o_rsp_valid),
    .o_rsp_t       (o_rsp_t),
    .o_rsp_hit     (o_rsp_hit),
    .i_drain       (i_drain),
    .o_idle        (o_idle),
    .o_err         (o_err)
  );

  always #5 i_clk = ~i_clk;

  // Reference model state
  int           m_last;      // last granted requester
  int           m_outq[$];   // owners of outstanding requests, issue order
  logic         m_en;
  logic [287:0] m_tri;
  logic [191:0] m_ray;
  logic [N-1:0] m_rsp;
  logic [31:0]  m_t;
  logic         m_hit;
  logic         m_err;
  logic         m_idle;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [287:0] got, input logic [287:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_last = N - 1;
    m_outq.delete();
    m_en   = 1'b0;
    m_tri  = '0;
    m_ray  = '0;
    m_rsp  = '0;
    m_t    = '0;
    m_hit  = 1'b0;
    m_err  = 1'b0;
    m_idle = 1'b1;
  endtask

  // Requester the arbiter should accept this cycle, as a one-hot vector
  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    r = '0;
    if (i_rstn && !i_drain && m_outq.size() < D) begin
      for (int k = 1; k <= N; k++) begin
        if (r == '0 && i_req_valid[(m_last + k) % N]) r[(m_last + k) % N] = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic check_all();
    chk("ready",     {284'b0, o_req_ready}, {284'b0, exp_ready()});
    chk("isect_en",  {287'b0, o_isect_en},  {287'b0, m_en});
    chk("isect_tri", o_isect_tri,           m_tri);
    chk("isect_ray", {96'b0, o_isect_ray},  {96'b0, m_ray});
    chk("rsp_valid", {284'b0, o_rsp_valid}, {284'b0, m_rsp});
    chk("rsp_t",     {256'b0, o_rsp_t},     {256'b0, m_t});
    chk("rsp_hit",   {287'b0, o_rsp_hit},   {287'b0, m_hit});
    chk("idle",      {287'b0, o_idle},      {287'b0, m_idle});
    chk("err",       {287'b0, o_err},       {287'b0, m_err});
  endtask

  // One clock: check at the falling edge, then advance the model across the rising edge
  task automatic step();
    logic [N-1:0] r;
    logic         n_en;
    logic [287:0] n_tri;
    logic [191:0] n_ray;
    logic [N-1:0] n_rsp;
    logic [31:0]  n_t;
    logic         n_hit, n_err;
    int           n_last;
    logic         in_rst;
    @(negedge i_clk);
    check_all();
    in_rst = !i_rstn;
    r      = exp_ready();
    n_en   = 1'b0;
    n_tri  = m_tri;
    n_ray  = m_ray;
    n_rsp  = '0;
    n_t    = m_t;
    n_hit  = m_hit;
    n_err  = m_err;
    n_last = m_last;
    if (!in_rst) begin
      if (i_isect_valid) begin
        if (m_outq.size() > 0) begin
          n_rsp[m_outq.pop_front()] = 1'b1;
          n_t   = i_isect_t;
          n_hit = i_isect_hit;
        end else begin
          n_err = 1'b1;
        end
      end
      for (int g = 0; g < N; g++) begin
        if (r[g] && i_req_valid[g]) begin
          n_en   = 1'b1;
          n_tri  = i_req_tri[g*288 +: 288];
          n_ray  = i_req_ray[g*192 +: 192];
          n_last = g;
          m_outq.push_back(g);
        end
      end
    end
    @(posedge i_clk);
    #1;
    if (in_rst || !i_rstn) begin
      model_reset();
    end else begin
      m_en   = n_en;
      m_tri  = n_tri;
      m_ray  = n_ray;
      m_rsp  = n_rsp;
      m_t    = n_t;
      m_hit  = n_hit;
      m_err  = n_err;
      m_last = n_last;
      m_idle = (m_outq.size() == 0) && !n_en && (n_rsp == '0);
    end
  endtask

  task automatic rand_data();
    for (int w = 0; w < N * 9; w++) i_req_tri[w*32 +: 32] = $urandom;
    for (int w = 0; w < N * 6; w++) i_req_ray[w*32 +: 32] = $urandom;
  endtask

  initial begin
    i_rstn        = 1'b0;
    i_req_valid   = '0;
    i_req_tri     = '0;
    i_req_ray     = '0;
    i_isect_valid = 1'b0;
    i_isect_t     = '0;
    i_isect_hit   = 1'b0;
    i_drain       = 1'b0;
    model_reset();
    repeat (2) step();
    i_rstn = 1'b1;
    step();

    // Single requester, result after five cycles
    rand_data();
    i_req_valid = 4'b0001;
    step();
    i_req_valid = '0;
    repeat (4) step();
    i_isect_valid = 1'b1;
    i_isect_t     = 32'h0001_8000;
    i_isect_hit   = 1'b1;
    step();
    i_isect_valid = 1'b0;
    chk("single_rsp_valid", {284'b0, o_rsp_valid}, 288'h1);
    chk("single_rsp_t", {256'b0, o_rsp_t}, 288'h1_8000);
    repeat (2) step();

    // All requesters valid: rotation, then the depth limit stalls grants
    i_req_valid = 4'hf;
    for (int c = 0; c < 6; c++) begin
      rand_data();
      step();
    end
    i_isect_valid = 1'b1;
    i_isect_t     = $urandom;
    step();
    i_isect_valid = 1'b0;
    rand_data();
    step();
    i_req_valid = '0;
    for (int c = 0; c < 4; c++) begin
      i_isect_valid = 1'b1;
      i_isect_t     = $urandom;
      i_isect_hit   = 1'($urandom);
      step();
    end
    i_isect_valid = 1'b0;
    repeat (2) step();

    // Result with nothing outstanding
    i_isect_valid = 1'b1;
    step();
    i_isect_valid = 1'b0;
    repeat (2) step();

    // Reset with three outstanding, asserted between clock edges
    i_rstn = 1'b0;
    #1;
    model_reset();
    step();
    i_rstn = 1'b1;
    step();
    i_req_valid = 4'hf;
    for (int c = 0; c < 3; c++) begin
      rand_data();
      step();
    end
    i_req_valid = '0;
    step();
    #2;
    i_rstn = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (2) step();
    i_rstn = 1'b1;
    step();
    i_isect_valid = 1'b1;
    step();
    i_isect_valid = 1'b0;
    step();
    i_rstn = 1'b0;
    #1;
    model_reset();
    step();
    i_rstn = 1'b1;
    step();

    // Drain with two outstanding
    i_req_valid = 4'b0011;
    rand_data();
    repeat (2) step();
    i_drain     = 1'b1;
    i_req_valid = 4'hf;
    repeat (2) step();
    i_isect_valid = 1'b1;
    repeat (2) step();
    i_isect_valid = 1'b0;
    repeat (3) step();
    i_drain     = 1'b0;
    i_req_valid = '0;
    step();

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      rand_data();
      i_req_valid   = 4'($urandom);
      i_drain       = ($urandom_range(0, 7) == 0);
      i_isect_valid = ($urandom_range(0, 2) == 0);
      i_isect_t     = $urandom;
      i_isect_hit   = 1'($urandom);
      if (c == 200) begin
        i_rstn = 1'b0;
        #1;
        model_reset();
      end else if (c == 202) begin
        i_rstn = 1'b1;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
